// File: rtl/rcvbuf_fifo.sv
// Receive buffer: collects UART RX words, then streams them out one bit per bit_tick.
// Optional early drain via the flush input when RCVBUF_FLUSH_EN is defined.
module rcvbuf_fifo #(
  parameter int DEPTH_BITS = 10000,
  parameter int WORD_W     = 8,
  parameter int LSB_FIRST  = 1
) (
  input  logic              rcvbuf_clk,
  input  logic              rcvbuf_rst_n,
  input  logic              bit_tick,
  input  logic              newdata,
  input  logic [WORD_W-1:0] rbr,
`ifdef RCVBUF_FLUSH_EN
  input  logic              flush,
`endif
  output logic              databit,
  output logic              dataval,
  output logic              full,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int WORDS = DEPTH_BITS / WORD_W;
  localparam int PW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [PW-1:0] LAST_WORD = PW'(WORDS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_DRAIN     = 2'd1
`ifdef RCVBUF_FLUSH_EN
    ,
    ST_FLUSH_REQ = 2'd2
`endif
  } state_t;

  state_t            r_state;
  logic              r_nd_s1;
  logic              r_nd_s2;
  logic              r_nd_s3;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_end_ptr;
  logic [BW-1:0]     r_bit_idx;
  logic              r_last_out;
  logic [WORD_W-1:0] r_mem [WORDS];

  logic              w_event;
  logic              w_wr_en;
  logic              w_last_wr;
  logic [BW-1:0]     w_sel;
  logic [WORD_W-1:0] w_word;
  logic              w_bit;

  assign w_event   = r_nd_s2 & ~r_nd_s3;
  assign w_wr_en   = w_event && (r_state == ST_FILL);
  assign w_last_wr = w_event && (r_wr_ptr == LAST_WORD);
  assign w_sel     = (LSB_FIRST != 0) ? r_bit_idx : (LAST_BIT - r_bit_idx);
  assign w_word    = r_mem[r_rd_ptr];
  assign w_bit     = w_word[w_sel];
  assign dbg_state = r_state;

  // Storage is deliberately not reset; dataval gating keeps stale words off the line.
  always_ff @(posedge rcvbuf_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= rbr;
    end
  end

  always_ff @(posedge rcvbuf_clk or negedge rcvbuf_rst_n) begin
    if (!rcvbuf_rst_n) begin
      r_state    <= ST_FILL;
      r_nd_s1    <= 1'b0;
      r_nd_s2    <= 1'b0;
      r_nd_s3    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_end_ptr  <= '0;
      r_bit_idx  <= '0;
      r_last_out <= 1'b0;
      databit    <= 1'b0;
      dataval    <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_nd_s1 <= newdata;
      r_nd_s2 <= r_nd_s1;
      r_nd_s3 <= r_nd_s2;
      case (r_state)
        ST_FILL: begin
          if (w_event) begin
            if (w_last_wr) begin
              r_wr_ptr  <= '0;
              r_end_ptr <= LAST_WORD;
              full      <= 1'b1;
              r_state   <= ST_DRAIN;
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
            end
          end
`ifdef RCVBUF_FLUSH_EN
          // A word landing on the flush cycle is included in the drain.
          if (flush && (r_wr_ptr != '0) && !w_last_wr) begin
            r_state <= ST_FLUSH_REQ;
          end
`endif
        end
`ifdef RCVBUF_FLUSH_EN
        ST_FLUSH_REQ: begin
          if (w_event) begin
            overflow <= 1'b1;
          end
          r_end_ptr <= r_wr_ptr - PW'(1);
          r_state   <= ST_DRAIN;
        end
`endif
        ST_DRAIN: begin
          if (w_event) begin
            overflow <= 1'b1;
          end
          if (bit_tick) begin
            if (r_last_out) begin
              databit    <= 1'b0;
              dataval    <= 1'b0;
              full       <= 1'b0;
              r_wr_ptr   <= '0;
              r_rd_ptr   <= '0;
              r_bit_idx  <= '0;
              r_last_out <= 1'b0;
              r_state    <= ST_FILL;
            end else begin
              databit <= w_bit;
              dataval <= 1'b1;
              if (r_bit_idx == LAST_BIT) begin
                r_bit_idx <= '0;
                if (r_rd_ptr == r_end_ptr) begin
                  r_rd_ptr   <= '0;
                  r_last_out <= 1'b1;
                end else begin
                  r_rd_ptr <= r_rd_ptr + PW'(1);
                end
              end else begin
                r_bit_idx <= r_bit_idx + BW'(1);
              end
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule
